// File: rtl/alu_sequencer_if.sv
// rtl/alu_sequencer_if.sv - instruction-memory, ALU and register-file control bundle of the ALU sequencer
//
// Ports (master = sequencer side):
//   instr      in   8  instruction memory read data (registered memory)
//   alu_z/n/c/v in  1  ALU status flags, combinational from the ALU
//   imem_addr  out  8  instruction address
//   alu_sel    out  3  ALU operation select
//   rf_ra      out  2  register-file read port A address
//   rf_rb      out  2  register-file read port B address
//   rf_wa      out  2  register-file write address
//   rf_we      out  1  register-file write enable
//   wb_sel     out  1  write-back source: 0 = ALU result, 1 = wb_imm
//   wb_imm     out  8  immediate write-back data
//   flags      out  4  registered {Z,N,C,V}
//   halted     out  1  high while halted
interface alu_sequencer_if;
   logic [7:0] instr;
   logic       alu_z;
   logic       alu_n;
   logic       alu_c;
   logic       alu_v;
   logic [7:0] imem_addr;
   logic [2:0] alu_sel;
   logic [1:0] rf_ra;
   logic [1:0] rf_rb;
   logic [1:0] rf_wa;
   logic       rf_we;
   logic       wb_sel;
   logic [7:0] wb_imm;
   logic [3:0] flags;
   logic       halted;

   modport master (
      input  instr, alu_z, alu_n, alu_c, alu_v,
      output imem_addr, alu_sel, rf_ra, rf_rb, rf_wa, rf_we, wb_sel, wb_imm, flags, halted
   );

   modport slave (
      output instr, alu_z, alu_n, alu_c, alu_v,
      input  imem_addr, alu_sel, rf_ra, rf_rb, rf_wa, rf_we, wb_sel, wb_imm, flags, halted
   );
endinterface

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - multi-cycle fetch/decode/execute control FSM for the 8-bit ALU datapath
//
// Ports:
//   clk  in   1  system clock, rising edge
//   rst  in   1  synchronous active-high reset
//   bus  master modport of alu_sequencer_if (memory, ALU, register file, flags, halted)
// Parameters:
//   RESET_PC  PC value loaded on reset
module alu_sequencer #(
   parameter logic [7:0] RESET_PC = 8'h00
) (
   input  logic             clk,
   input  logic             rst,
   alu_sequencer_if.master  bus
);

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_IMM_WAIT,
      S_IMM,
      S_HALT
   } state_t;

   localparam logic [3:0] OP_LDI  = 4'b1000;
   localparam logic [3:0] OP_JMP  = 4'b1001;
   localparam logic [3:0] OP_JZ   = 4'b1010;
   localparam logic [3:0] OP_JC   = 4'b1011;
   localparam logic [3:0] OP_CMP  = 4'b1100;
   localparam logic [3:0] OP_HALT = 4'b1111;

   // flags_q bit positions within {Z,N,C,V}
   localparam int FLAG_Z = 3;
   localparam int FLAG_C = 1;

   state_t     state_q, state_d;
   logic [7:0] pc_q, pc_d;
   logic [7:0] ir_q, ir_d;
   logic [3:0] flags_q, flags_d;

   logic [3:0] op_ir;
   logic [3:0] op_in;
   logic       ir_is_alu;
   logic       ir_is_cmp;
   logic [7:0] pc_inc;

   assign op_ir     = ir_q[7:4];
   assign op_in     = bus.instr[7:4];
   assign ir_is_alu = ~ir_q[7];
   assign ir_is_cmp = (op_ir == OP_CMP);
   assign pc_inc    = pc_q + 8'd1;   // 8-bit, wraps 0xFF -> 0x00

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_FETCH;
         pc_q    <= RESET_PC;
         ir_q    <= 8'h00;
         flags_q <= 4'h0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         flags_q <= flags_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      ir_d       = ir_q;
      flags_d    = flags_q;
      bus.rf_we  = 1'b0;
      bus.wb_sel = 1'b0;
      bus.wb_imm = 8'h00;

      case (state_q)
         S_FETCH: begin
            state_d = S_DECODE;
         end

         S_DECODE: begin
            // ir is still the previous instruction here, so decode from instr
            ir_d = bus.instr;
            pc_d = pc_inc;
            if (!op_in[3] || op_in == OP_CMP) begin
               state_d = S_EXEC;
            end else if (op_in[3:2] == 2'b10) begin
               state_d = S_IMM_WAIT;
            end else if (op_in == OP_HALT) begin
               state_d = S_HALT;
            end else begin
               state_d = S_FETCH;
            end
         end

         S_EXEC: begin
            bus.rf_we = ir_is_alu;
            flags_d   = {bus.alu_z, bus.alu_n, bus.alu_c, bus.alu_v};
            state_d   = S_FETCH;
         end

         S_IMM_WAIT: begin
            // memory is registered: operand at pc appears on instr next cycle
            state_d = S_IMM;
         end

         S_IMM: begin
            state_d = S_FETCH;
            case (op_ir)
               OP_LDI: begin
                  bus.rf_we  = 1'b1;
                  bus.wb_sel = 1'b1;
                  bus.wb_imm = bus.instr;
                  pc_d       = pc_inc;
               end
               OP_JMP:  pc_d = bus.instr;
               OP_JZ:   pc_d = flags_q[FLAG_Z] ? bus.instr : pc_inc;
               OP_JC:   pc_d = flags_q[FLAG_C] ? bus.instr : pc_inc;
               default: pc_d = pc_inc;
            endcase
         end

         S_HALT: begin
            state_d = S_HALT;
         end

         default: begin
            state_d = S_FETCH;
         end
      endcase
   end

   assign bus.imem_addr = pc_q;
   assign bus.alu_sel   = ir_is_alu ? ir_q[6:4] : (ir_is_cmp ? 3'b001 : 3'b000);
   assign bus.rf_ra     = ir_q[3:2];
   assign bus.rf_wa     = ir_q[3:2];
   assign bus.rf_rb     = ir_q[1:0];
   assign bus.flags     = flags_q;
   assign bus.halted    = (state_q == S_HALT);

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - self-checking bench for alu_sequencer
module tb_alu_sequencer;

   typedef struct packed {
      logic [7:0] addr;
      logic [2:0] sel;
      logic [1:0] ra;
      logic [1:0] rb;
      logic [1:0] wa;
      logic       we;
      logic       wbs;
      logic [7:0] imm;
      logic [3:0] fl;
      logic       h;
   } exp_t;

   typedef struct {
      int         cyc;
      int         fld;
      logic [7:0] val;
   } lit_t;

   localparam int F_ADDR = 0;
   localparam int F_SEL  = 1;
   localparam int F_WA   = 2;
   localparam int F_RB   = 3;
   localparam int F_WE   = 4;
   localparam int F_WBS  = 5;
   localparam int F_IMM  = 6;
   localparam int F_FL   = 7;
   localparam int F_H    = 8;

   logic clk;
   logic rst;
   alu_sequencer_if bus ();

   alu_sequencer #(.RESET_PC(8'h00)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [7:0] mem_m [256];
   logic [3:0] alu_flags;
   exp_t       exp_q [$];
   lit_t       lits  [$];
   exp_t       act;
   exp_t       e;
   int         tests;
   int         fails;
   int         cyc;
   bit         check_en;
   string      phase;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // registered instruction memory
   always @(posedge clk) bus.instr <= mem_m[bus.imem_addr];

   assign {bus.alu_z, bus.alu_n, bus.alu_c, bus.alu_v} = alu_flags;

   function automatic logic [2:0] exp_sel(input logic [7:0] ir);
      if (ir[7] == 1'b0) return ir[6:4];
      if (ir[7:4] == 4'hC) return 3'b001;
      return 3'b000;
   endfunction

   function automatic exp_t mk(input logic [7:0] pc, input logic [7:0] ir, input logic [3:0] fl,
                               input logic we, input logic wbs, input logic [7:0] imm, input logic h);
      exp_t r;
      r.addr = pc;
      r.sel  = exp_sel(ir);
      r.ra   = ir[3:2];
      r.rb   = ir[1:0];
      r.wa   = ir[3:2];
      r.we   = we;
      r.wbs  = wbs;
      r.imm  = imm;
      r.fl   = fl;
      r.h    = h;
      return r;
   endfunction

   function automatic logic [7:0] field(input exp_t a, input int f);
      case (f)
         F_ADDR:  return a.addr;
         F_SEL:   return {5'd0, a.sel};
         F_WA:    return {6'd0, a.wa};
         F_RB:    return {6'd0, a.rb};
         F_WE:    return {7'd0, a.we};
         F_WBS:   return {7'd0, a.wbs};
         F_IMM:   return a.imm;
         F_FL:    return {4'd0, a.fl};
         F_H:     return {7'd0, a.h};
         default: return 8'h00;
      endcase
   endfunction

   // Instruction-level interpreter: walks the program from reset and lists the
   // expected outputs for each clock cycle according to each instruction's length.
   task automatic gen_expected(input int n);
      logic [7:0] pc = 8'h00;
      logic [7:0] ir = 8'h00;
      logic [7:0] opd;
      logic [3:0] fl = 4'h0;
      logic [3:0] op;
      exp_q.delete();
      while (exp_q.size() < n) begin
         exp_q.push_back(mk(pc, ir, fl, 1'b0, 1'b0, 8'h00, 1'b0));   // fetch
         exp_q.push_back(mk(pc, ir, fl, 1'b0, 1'b0, 8'h00, 1'b0));   // decode
         ir = mem_m[pc];
         pc = pc + 8'd1;
         op = ir[7:4];
         if (op == 4'hF) begin
            while (exp_q.size() < n) exp_q.push_back(mk(pc, ir, fl, 1'b0, 1'b0, 8'h00, 1'b1));
         end else if (op < 4'h8 || op == 4'hC) begin
            exp_q.push_back(mk(pc, ir, fl, (op < 4'h8), 1'b0, 8'h00, 1'b0));
            fl = alu_flags;
         end else if (op <= 4'hB) begin
            exp_q.push_back(mk(pc, ir, fl, 1'b0, 1'b0, 8'h00, 1'b0));   // operand wait
            opd = mem_m[pc];
            if (op == 4'h8) begin
               exp_q.push_back(mk(pc, ir, fl, 1'b1, 1'b1, opd, 1'b0));
               pc = pc + 8'd1;
            end else begin
               exp_q.push_back(mk(pc, ir, fl, 1'b0, 1'b0, 8'h00, 1'b0));
               if (op == 4'h9)      pc = opd;
               else if (op == 4'hA) pc = fl[3] ? opd : pc + 8'd1;
               else                 pc = fl[1] ? opd : pc + 8'd1;
            end
         end
      end
      while (exp_q.size() > n) void'(exp_q.pop_back());
   endtask

   task automatic add_lit(input int c, input int f, input logic [7:0] v);
      lit_t l;
      l.cyc = c;
      l.fld = f;
      l.val = v;
      lits.push_back(l);
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) mem_m[i] = 8'hD0;
   endtask

   // Called just after a rising edge: reset for one edge, then compare n cycles.
   task automatic run_phase(input string name, input int n);
      int guard;
      #1;
      rst   = 1'b1;
      phase = name;
      gen_expected(n);
      @(posedge clk);
      #1;
      rst      = 1'b0;
      cyc      = 0;
      check_en = 1'b1;
      guard    = 0;
      while (exp_q.size() > 0 && guard < n + 5) begin
         @(posedge clk);
         guard++;
      end
      check_en = 1'b0;
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL %s timeout: %0d cycles left, required 0", name, exp_q.size());
      end
      lits.delete();
   endtask

   always @(negedge clk) begin
      if (check_en && exp_q.size() > 0) begin
         e        = exp_q.pop_front();
         act.addr = bus.imem_addr;
         act.sel  = bus.alu_sel;
         act.ra   = bus.rf_ra;
         act.rb   = bus.rf_rb;
         act.wa   = bus.rf_wa;
         act.we   = bus.rf_we;
         act.wbs  = bus.wb_sel;
         act.imm  = bus.wb_imm;
         act.fl   = bus.flags;
         act.h    = bus.halted;
         tests++;
         if (act !== e) begin
            fails++;
            $display("FAIL %s cycle %0d outputs: got addr=%h sel=%h ra=%h rb=%h wa=%h we=%b wbs=%b imm=%h fl=%b h=%b, required addr=%h sel=%h ra=%h rb=%h wa=%h we=%b wbs=%b imm=%h fl=%b h=%b",
                     phase, cyc, act.addr, act.sel, act.ra, act.rb, act.wa, act.we, act.wbs, act.imm, act.fl, act.h,
                     e.addr, e.sel, e.ra, e.rb, e.wa, e.we, e.wbs, e.imm, e.fl, e.h);
         end
         foreach (lits[i]) begin
            if (lits[i].cyc == cyc) begin
               tests++;
               if (field(act, lits[i].fld) !== lits[i].val) begin
                  fails++;
                  $display("FAIL %s literal cycle %0d field %0d: got %h, required %h",
                           phase, cyc, lits[i].fld, field(act, lits[i].fld), lits[i].val);
               end
            end
         end
         cyc++;
      end
   end

   initial begin
      rst       = 1'b1;
      check_en  = 1'b0;
      tests     = 0;
      fails     = 0;
      cyc       = 0;
      alu_flags = 4'h0;
      phase     = "init";
      clear_mem();
      repeat (2) @(posedge clk);

      // ADD r1,r2 then LDI r3,0x5A then HALT
      clear_mem();
      mem_m[8'h00] = 8'h06; mem_m[8'h01] = 8'h8C; mem_m[8'h02] = 8'h5A; mem_m[8'h03] = 8'hF0;
      alu_flags = 4'b0101;
      add_lit(0, F_ADDR, 8'h00); add_lit(0, F_FL, 8'h0); add_lit(0, F_WE, 8'h0); add_lit(0, F_H, 8'h0);
      add_lit(2, F_SEL, 8'h0); add_lit(2, F_WA, 8'h1); add_lit(2, F_RB, 8'h2); add_lit(2, F_WE, 8'h1);
      add_lit(3, F_WE, 8'h0); add_lit(3, F_FL, 8'h5); add_lit(3, F_ADDR, 8'h01);
      add_lit(6, F_WE, 8'h1); add_lit(6, F_WBS, 8'h1); add_lit(6, F_IMM, 8'h5A); add_lit(6, F_WA, 8'h3);
      add_lit(6, F_FL, 8'h5); add_lit(7, F_ADDR, 8'h03); add_lit(9, F_H, 8'h1);
      run_phase("add_ldi", 14);

      // CMP with Z=1 then JZ 0x40 taken
      clear_mem();
      mem_m[8'h00] = 8'hC1; mem_m[8'h01] = 8'hA0; mem_m[8'h02] = 8'h40; mem_m[8'h40] = 8'hF0;
      alu_flags = 4'b1010;
      add_lit(2, F_SEL, 8'h1); add_lit(2, F_WE, 8'h0); add_lit(3, F_FL, 8'hA); add_lit(7, F_ADDR, 8'h40);
      run_phase("cmp_jz_taken", 12);

      // CMP with Z=0, C=1: JZ falls through, then JC 0x80 taken
      clear_mem();
      mem_m[8'h00] = 8'hC1; mem_m[8'h01] = 8'hA0; mem_m[8'h02] = 8'h40;
      mem_m[8'h03] = 8'hB0; mem_m[8'h04] = 8'h80; mem_m[8'h80] = 8'hF0;
      alu_flags = 4'b0010;
      add_lit(3, F_FL, 8'h2); add_lit(7, F_ADDR, 8'h03); add_lit(11, F_ADDR, 8'h80);
      run_phase("cmp_jz_not_jc", 14);

      // SUB r0,r1, JMP 0xFF, LDI r0 at 0xFF takes its operand from 0x00
      clear_mem();
      mem_m[8'h00] = 8'h11; mem_m[8'h01] = 8'h90; mem_m[8'h02] = 8'hFF; mem_m[8'hFF] = 8'h80;
      alu_flags = 4'b0100;
      add_lit(2, F_SEL, 8'h1); add_lit(7, F_ADDR, 8'hFF); add_lit(9, F_ADDR, 8'h00);
      add_lit(10, F_IMM, 8'h11); add_lit(10, F_WA, 8'h0); add_lit(10, F_WE, 8'h1);
      add_lit(11, F_ADDR, 8'h01);
      run_phase("jmp_wrap", 12);

      // HALT holds for 20+ cycles
      clear_mem();
      mem_m[8'h00] = 8'hF0;
      alu_flags = 4'b1111;
      add_lit(1, F_H, 8'h0); add_lit(2, F_H, 8'h1); add_lit(22, F_ADDR, 8'h01); add_lit(22, F_WE, 8'h0);
      run_phase("halt", 25);

      // reset out of HALT, then run CMP + JMP up to the operand-wait cycle
      clear_mem();
      mem_m[8'h00] = 8'hC1; mem_m[8'h01] = 8'h90; mem_m[8'h02] = 8'h40;
      alu_flags = 4'b1000;
      add_lit(0, F_H, 8'h0); add_lit(0, F_ADDR, 8'h00); add_lit(0, F_FL, 8'h0); add_lit(0, F_WE, 8'h0);
      add_lit(3, F_FL, 8'h8);
      run_phase("rst_from_halt", 5);

      // reset landed during the JMP operand wait with flags=1000
      clear_mem();
      mem_m[8'h00] = 8'hF0;
      alu_flags = 4'b0000;
      add_lit(0, F_ADDR, 8'h00); add_lit(0, F_FL, 8'h0); add_lit(0, F_WE, 8'h0); add_lit(0, F_H, 8'h0);
      run_phase("rst_mid_jmp", 4);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Multi-cycle control FSM for the 8-bit ALU datapath.
- Fetches one- and two-byte instructions from a synchronous instruction memory and decodes them.
- Drives the ALU operation select, register-file read/write addresses and write enable, and the write-back mux.
- Holds the architectural Z/N/C/V flag register used by conditional jumps.

Parameters:
RESET_PC, 8'h00, PC value loaded on reset.

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
instr  in  8  instruction memory read data; registered memory, valid the cycle after imem_addr is stable
alu_z  in  1  ALU Zero flag (combinational from ALU)
alu_n  in  1  ALU Negative flag
alu_c  in  1  ALU Carry flag
alu_v  in  1  ALU Overflow flag
imem_addr  out  8  instruction address (= pc register)
alu_sel  out  3  ALU operation select
rf_ra  out  2  register-file read port A address (rd field)
rf_rb  out  2  register-file read port B address (rs field)
rf_wa  out  2  register-file write address (rd field)
rf_we  out  1  register-file write enable
wb_sel  out  1  write-back source: 0 = ALU result, 1 = wb_imm
wb_imm  out  8  immediate write-back data
flags  out  4  registered {Z,N,C,V}
halted  out  1  high while in HALT

Behaviour:
- Synchronous active-high reset on clk.
  - Reset state: state=FETCH, pc=RESET_PC, ir=0, flags=0, halted=0.
  - Reset overrides everything, including mid-instruction and HALT.
- Instruction byte ir[7:4]=opcode, ir[3:2]=rd, ir[1:0]=rs.
- Opcodes:
  - 0000-0111: ALU op. alu_sel=opcode[2:0]; rd <= rd op rs; flags updated.
  - 1000 LDI: rd <= next byte.
  - 1001 JMP: pc <= next byte.
  - 1010 JZ: jump to next byte if flags.Z.
  - 1011 JC: jump to next byte if flags.C.
  - 1100 CMP: alu_sel=001 (SUB); flags updated; no write.
  - 1111 HALT.
  - 1101, 1110: NOP (one-byte).
- States and transitions:
  - FETCH: imem_addr=pc held → DECODE.
  - DECODE: ir<=instr, pc<=pc+1.
    - → EXEC if ALU/CMP.
    - → IMM_WAIT if LDI/JMP/JZ/JC.
    - → HALT if HALT.
    - → FETCH if NOP.
  - EXEC: alu_sel from ir.
    - ALU op: rf_we=1, wb_sel=0.
    - ALU op and CMP: flags <= {alu_z,alu_n,alu_c,alu_v}.
    - → FETCH.
  - IMM_WAIT: memory reads operand at pc → IMM.
  - IMM: operand = instr.
    - LDI: rf_we=1, wb_sel=1, wb_imm=instr, pc<=pc+1.
    - JMP: pc<=instr.
    - JZ/JC: pc<=instr if condition flag set, else pc<=pc+1.
    - → FETCH.
  - HALT: halted=1, pc frozen, no writes; exits only on rst.
- Latency: ALU/CMP/NOP 3 cycles (NOP 2: FETCH, DECODE); LDI/JMP/JZ/JC 4 cycles; every instruction starts in FETCH.
- Outputs outside their active states:
  - rf_we=0.
  - wb_sel=0.
  - wb_imm=0.
  - alu_sel=ir[6:4] when ir is an ALU op, 001 for CMP, otherwise 000.
- Addresses:
  - rf_ra and rf_wa = ir[3:2]; rf_rb = ir[1:0], always driven from ir.
  - rf_we is decoded from state and ir only; the only combinational path from instr is wb_imm during IMM.
- Flags change only in EXEC. LDI, jumps and NOP leave flags unchanged. A conditional jump reads the flags register value held before the IMM cycle.
- pc is 8-bit and wraps: 0xFF+1 = 0x00.
  - Wrap applies on increment in DECODE and IMM.
  - A two-byte instruction at 0xFF fetches its operand from 0x00.

Test Plan:
- Reset, then ALU op ADD r1,r2 (instr 0x06) with ALU returning Z=0,N=1,C=0,V=1 → imem_addr 0x00; DECODE; EXEC with alu_sel=000, rf_wa=1, rf_rb=2, rf_we=1 for exactly one cycle; flags=4'b0101; imem_addr=0x01 at next FETCH.
- LDI r3 (0x8C, 0x5A at addrs 0x01,0x02) → in 4th cycle rf_we=1, wb_sel=1, wb_imm=0x5A, rf_wa=3; flags unchanged; next FETCH at 0x03.
- CMP with ALU Z=1 (instr 0xC1), then JZ 0x40 (0xA0,0x40) → CMP: alu_sel=001, rf_we=0, flags.Z=1; JZ: next FETCH at 0x40. Repeat with Z=0 → next FETCH at pc+2.
- JMP 0xFF, instr at 0xFF = LDI r0 with operand at 0x00 = 0x11 → operand fetched from imem_addr 0x00; wb_imm=0x11; next FETCH at 0x01.
- HALT (0xF0) → halted=1 from the cycle after DECODE; imem_addr frozen and rf_we=0 for 20 cycles.
- rst asserted in IMM_WAIT of a JMP, and separately in HALT → next cycle state=FETCH, pc=RESET_PC, flags=0, halted=0, rf_we=0.
